// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and size helpers.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STROBE  = 2'b01,
    ST_RELEASE = 2'b10,
    ST_RESP    = 2'b11
  } lsu_state_e;

  // Offset of the last byte of an access (nbytes-1); the illegal size maps to 0.
  function automatic logic [1:0] size_last_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SIZE_BYTE: idx = 2'd0;
      SIZE_HALF: idx = 2'd1;
      SIZE_WORD: idx = 2'd3;
      default:   idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when the address is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_data_align.sv
// Data path helpers for the load/store unit: big-endian byte-lane selection for
// split store beats and final sign/zero extension of an assembled split load.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_split,
  input  logic [1:0]  i_beat,
  input  logic [31:0] i_acc,
  input  logic        i_signed,
  output logic [31:0] o_beat_wdata,
  output logic [31:0] o_ext_data
);

  logic [1:0] w_lane;

  // Store beat data: the full word when aligned, otherwise the byte for this beat
  // (beat 0 carries the most-significant byte of the access).
  always_comb begin
    w_lane       = size_last_idx(i_size) - i_beat;
    o_beat_wdata = 32'h0000_0000;
    if (i_split) begin
      case (w_lane)
        2'd0:    o_beat_wdata = {24'h00_0000, i_wdata[7:0]};
        2'd1:    o_beat_wdata = {24'h00_0000, i_wdata[15:8]};
        2'd2:    o_beat_wdata = {24'h00_0000, i_wdata[23:16]};
        2'd3:    o_beat_wdata = {24'h00_0000, i_wdata[31:24]};
        default: o_beat_wdata = 32'h0000_0000;
      endcase
    end else begin
      o_beat_wdata = i_wdata;
    end
  end

  // Extension of the assembled bytes; a word is returned unchanged.
  always_comb begin
    o_ext_data = 32'h0000_0000;
    case (i_size)
      SIZE_BYTE: o_ext_data = {{24{i_signed & i_acc[7]}}, i_acc[7:0]};
      SIZE_HALF: o_ext_data = {{16{i_signed & i_acc[15]}}, i_acc[15:0]};
      SIZE_WORD: o_ext_data = i_acc;
      default:   o_ext_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the MEM stage, range-checks it,
// drives the big-endian data memory with one strobe per beat (splitting misaligned
// accesses into byte beats when enabled) and returns a single-cycle response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W           = 9,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic              mem_signext,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // FSM, beat counter and assembly register
  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [1:0]        r_beat;
  logic [1:0]        w_beat_nxt;
  logic [31:0]       r_acc;
  logic [31:0]       w_acc_nxt;
  logic              w_last_beat;

  // Latched request
  logic              r_we;
  logic              r_signed;
  logic              r_split;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  // Request view used for beat setup: live inputs while idle, latched copy otherwise
  logic              w_accept;
  logic              w_cur_we;
  logic              w_cur_signed;
  logic              w_cur_split;
  logic [1:0]        w_cur_size;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [31:0]       w_cur_wdata;

  // Request decode
  logic [ADDR_W:0]   w_req_end;
  logic              w_req_mis;
  logic              w_req_err;

  // Beat and response data
  logic [ADDR_W-1:0] w_beat_addr;
  logic [31:0]       w_beat_wdata;
  logic [31:0]       w_ext_data;
  logic [31:0]       w_resp_rdata;

  // Registered outputs
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic              r_mem_enable;
  logic              r_mem_rw;
  logic              r_mem_signext;
  logic [1:0]        r_mem_size;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Decode the live request so an error can go straight to RESP in the accept cycle.
  always_comb begin
    w_req_end = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_last_idx(req_size)};
    w_req_mis = is_misaligned(req_size, req_addr[1:0]);
    w_req_err = (req_size == SIZE_ILL)
             || (w_req_end > {1'b0, {ADDR_W{1'b1}}})
             || (w_req_mis && !SPLIT_MISALIGNED);
  end

  // Select live or latched request fields for setting up the next beat.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_cur_we     = req_we;
      w_cur_signed = req_signed;
      w_cur_split  = w_req_mis && SPLIT_MISALIGNED;
      w_cur_size   = req_size;
      w_cur_addr   = req_addr;
      w_cur_wdata  = req_wdata;
    end else begin
      w_cur_we     = r_we;
      w_cur_signed = r_signed;
      w_cur_split  = r_split;
      w_cur_size   = r_size;
      w_cur_addr   = r_addr;
      w_cur_wdata  = r_wdata;
    end
  end

  // Next-state and beat-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_last_beat = !r_split || (r_beat == size_last_idx(r_size));
    case (r_state)
      ST_IDLE: begin
        w_beat_nxt = 2'd0;
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_STROBE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STROBE: begin
        w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_last_beat) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_STROBE;
          w_beat_nxt  = r_beat + 2'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = 2'd0;
      end
    endcase
  end

  // Assembly register: cleared on accept, loaded from memory data in RELEASE of a load.
  always_comb begin
    w_acc_nxt = r_acc;
    if ((r_state == ST_RELEASE) && !r_we) begin
      if (r_split) begin
        w_acc_nxt = {r_acc[23:0], mem_rdata[7:0]};
      end else begin
        w_acc_nxt = mem_rdata;
      end
    end else if (w_accept) begin
      w_acc_nxt = 32'h0000_0000;
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  // Beat address: base address plus beat index (range already checked, no wrap).
  assign w_beat_addr = w_cur_addr + {{(ADDR_W-2){1'b0}}, w_beat_nxt};

  lsu_data_align u_align (
    .i_wdata      (w_cur_wdata),
    .i_size       (w_cur_size),
    .i_split      (w_cur_split),
    .i_beat       (w_beat_nxt),
    .i_acc        (w_acc_nxt),
    .i_signed     (w_cur_signed),
    .o_beat_wdata (w_beat_wdata),
    .o_ext_data   (w_ext_data)
  );

  // Load result for the response: aligned loads were extended by the memory itself.
  always_comb begin
    w_resp_rdata = 32'h0000_0000;
    if ((r_state == ST_RELEASE) && !r_we) begin
      if (r_split) begin
        w_resp_rdata = w_ext_data;
      end else begin
        w_resp_rdata = w_acc_nxt;
      end
    end else begin
      w_resp_rdata = 32'h0000_0000;
    end
  end

  // State, beat counter and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= 2'd0;
      r_acc   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Latch the request fields in the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_split  <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_split  <= w_req_mis && SPLIT_MISALIGNED;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end else begin
      r_we     <= r_we;
      r_signed <= r_signed;
      r_split  <= r_split;
      r_size   <= r_size;
      r_addr   <= r_addr;
      r_wdata  <= r_wdata;
    end
  end

  // Memory port: fields are loaded together with the strobe rising and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_enable  <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_signext <= 1'b0;
      r_mem_size    <= SIZE_BYTE;
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_mem_wdata   <= 32'h0000_0000;
    end else begin
      r_mem_enable <= (w_state_nxt == ST_STROBE);
      if (w_state_nxt == ST_STROBE) begin
        r_mem_rw      <= w_cur_we;
        r_mem_signext <= w_cur_split ? 1'b0 : w_cur_signed;
        r_mem_size    <= w_cur_split ? SIZE_BYTE : w_cur_size;
        r_mem_addr    <= w_beat_addr;
        r_mem_wdata   <= w_beat_wdata;
      end else begin
        r_mem_rw      <= r_mem_rw;
        r_mem_signext <= r_mem_signext;
        r_mem_size    <= r_mem_size;
        r_mem_addr    <= r_mem_addr;
        r_mem_wdata   <= r_mem_wdata;
      end
    end
  end

  // Pipeline-side handshake and response pulse; only an error enters RESP from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
    end else begin
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      r_resp_err   <= (w_state_nxt == ST_RESP) && (r_state == ST_IDLE);
      r_resp_rdata <= (w_state_nxt == ST_RESP) ? w_resp_rdata : 32'h0000_0000;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_enable  = r_mem_enable;
  assign mem_rw      = r_mem_rw;
  assign mem_signext = r_mem_signext;
  assign mem_size    = r_mem_size;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array data memory answers the strobes, a separate
// reference byte array tracks what every request should have done.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_enable, mem_rw, mem_signext;
  logic [1:0]  mem_size;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        ns_req_valid, ns_req_ready, ns_req_we, ns_req_signed;
  logic [1:0]  ns_req_size;
  logic [8:0]  ns_req_addr;
  logic [31:0] ns_req_wdata;
  logic        ns_resp_valid, ns_resp_err;
  logic [31:0] ns_resp_rdata;
  logic        ns_mem_enable, ns_mem_rw, ns_mem_signext;
  logic [1:0]  ns_mem_size;
  logic [8:0]  ns_mem_addr;
  logic [31:0] ns_mem_wdata;
  logic [31:0] ns_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int ns_strobes = 0;
  int resp_seen = 0;

  logic [7:0] mem     [512];
  logic [7:0] ref_mem [512];
  logic [8:0] strobe_addr_q [$];
  logic [7:0] strobe_byte_q [$];

  load_store_unit #(.ADDR_W(9), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_signext(mem_signext), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_W(9), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we), .req_size(ns_req_size),
    .req_signed(ns_req_signed), .req_addr(ns_req_addr), .req_wdata(ns_req_wdata),
    .resp_valid(ns_resp_valid), .resp_err(ns_resp_err), .resp_rdata(ns_resp_rdata),
    .mem_enable(ns_mem_enable), .mem_rw(ns_mem_rw), .mem_signext(ns_mem_signext), .mem_size(ns_mem_size),
    .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata), .mem_rdata(ns_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Data memory model: acts on the rising strobe, big-endian, extends reads itself.
  int          mm_nb;
  logic [31:0] mm_v;
  always @(posedge mem_enable) begin
    #1;
    strobe_cnt++;
    strobe_addr_q.push_back(mem_addr);
    strobe_byte_q.push_back(mem_wdata[7:0]);
    mm_nb = (mem_size == 2'b00) ? 1 : (mem_size == 2'b01) ? 2 : 4;
    if (mem_rw) begin
      for (int i = 0; i < mm_nb; i++)
        if (int'(mem_addr) + i < 512) mem[int'(mem_addr) + i] = 8'(mem_wdata >> (8 * (mm_nb - 1 - i)));
    end else begin
      mm_v = 32'h0;
      for (int i = 0; i < mm_nb; i++)
        if (int'(mem_addr) + i < 512) mm_v = (mm_v << 8) | {24'h0, mem[int'(mem_addr) + i]};
      if (mem_signext && mm_nb == 1 && mm_v[7])  mm_v = mm_v | 32'hFFFF_FF00;
      if (mem_signext && mm_nb == 2 && mm_v[15]) mm_v = mm_v | 32'hFFFF_0000;
      mem_rdata = mm_v;
    end
  end

  always @(posedge ns_mem_enable) ns_strobes++;
  always @(posedge clk) if (resp_valid === 1'b1) resp_seen++;

  // Strobe protocol watch: one-cycle strobes, address held through RELEASE.
  logic       mon_prev_en = 1'b0;
  logic [8:0] mon_prev_addr = 9'h0;
  always @(negedge clk) begin
    if (rst_n && mon_prev_en) begin
      check("strobe_one_cycle", {31'h0, mem_enable}, 32'h0);
      check("addr_held", {23'h0, mem_addr}, {23'h0, mon_prev_addr});
    end
    mon_prev_en   = mem_enable & rst_n;
    mon_prev_addr = mem_addr;
  end

  // One request on the main unit, checked against the reference byte array.
  task automatic lsu_op(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input int addr, input logic [31:0] wdata, output logic [31:0] obs_rd);
    int nb, lat, s0, exp_lat, exp_str;
    logic exp_err, mis;
    logic [31:0] exp_rd, v;
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis     = (addr % nb) != 0;
    exp_err = (size == 2'd3) || (addr + nb - 1 > 511);
    exp_str = exp_err ? 0 : (mis ? nb : 1);
    exp_lat = exp_err ? 1 : (mis ? 2 * nb + 1 : 3);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wdata >> (8 * (nb - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = (v << 8) | {24'h0, ref_mem[addr + i]};
        if (sgn && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        exp_rd = v;
      end
    end
    check({tag, ".ready_idle"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr[8:0]; req_wdata = wdata;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom; req_signed = $urandom;
    check({tag, ".busy"}, {31'h0, req_ready}, 32'h0);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    obs_rd = resp_rdata;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".strobes"}, strobe_cnt - s0, exp_str);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'h0, resp_valid}, 32'h0);
    check({tag, ".ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int s0, r0, t, diff, sel, a;
    logic [1:0] sz;

    for (int i = 0; i < 512; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem_rdata = 32'h0; ns_mem_rdata = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 9'h0; req_wdata = 32'h0;
    ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_size = 2'b00; ns_req_signed = 1'b0; ns_req_addr = 9'h0; ns_req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", {31'h0, req_ready}, 32'h1);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.mem_enable", {31'h0, mem_enable}, 32'h0);
    check("rst.mem_addr", {23'h0, mem_addr}, 32'h0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.ns_req_ready", {31'h0, ns_req_ready}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store and load
    lsu_op("t1.st", 1'b1, 2'b10, 1'b0, 'h010, 32'hDEAD_BEEF, rd);
    lsu_op("t1.ld", 1'b0, 2'b10, 1'b0, 'h010, 32'h0, rd);
    check("t1.value", rd, 32'hDEAD_BEEF);

    // Byte and halfword extension
    lsu_op("t2.stb", 1'b1, 2'b00, 1'b0, 'h020, 32'h0000_0080, rd);
    lsu_op("t2.lbs", 1'b0, 2'b00, 1'b1, 'h020, 32'h0, rd);
    check("t2.lbs_value", rd, 32'hFFFF_FF80);
    lsu_op("t2.lbu", 1'b0, 2'b00, 1'b0, 'h020, 32'h0, rd);
    check("t2.lbu_value", rd, 32'h0000_0080);
    lsu_op("t2.sth", 1'b1, 2'b01, 1'b0, 'h020, 32'h0000_8001, rd);
    lsu_op("t2.lhs", 1'b0, 2'b01, 1'b1, 'h020, 32'h0, rd);
    check("t2.lhs_value", rd, 32'hFFFF_8001);

    // Misaligned word split into byte beats
    strobe_addr_q.delete(); strobe_byte_q.delete();
    lsu_op("t3.st", 1'b1, 2'b10, 1'b0, 'h021, 32'h1122_3344, rd);
    check("t3.nbeats", strobe_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < strobe_addr_q.size(); i++) begin
      check("t3.beat_addr", {23'h0, strobe_addr_q[i]}, 32'h21 + i);
      check("t3.beat_byte", {24'h0, strobe_byte_q[i]}, 32'h11 * (i + 1));
    end
    lsu_op("t3.ld", 1'b0, 2'b10, 1'b0, 'h021, 32'h0, rd);
    check("t3.value", rd, 32'h1122_3344);
    lsu_op("t3.lhs_split", 1'b0, 2'b01, 1'b1, 'h023, 32'h0, rd);

    // Range and illegal-size errors
    lsu_op("t4.range", 1'b0, 2'b10, 1'b0, 'h1FE, 32'h0, rd);
    lsu_op("t4.range_st", 1'b1, 2'b01, 1'b0, 'h1FF, 32'hFFFF_FFFF, rd);
    lsu_op("t4.illegal", 1'b1, 2'b11, 1'b0, 'h040, 32'h1234_5678, rd);
    lsu_op("t4.top_byte", 1'b1, 2'b00, 1'b0, 'h1FF, 32'h0000_005A, rd);

    // Split disabled: misaligned halfword errors, aligned halfword still runs
    ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_size = 2'b01; ns_req_addr = 9'h003;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    check("t5.resp_valid", {31'h0, ns_resp_valid}, 32'h1);
    check("t5.resp_err", {31'h0, ns_resp_err}, 32'h1);
    check("t5.rdata", ns_resp_rdata, 32'h0);
    check("t5.no_strobe", ns_strobes, 0);
    @(posedge clk); #1;
    ns_req_valid = 1'b1; ns_req_we = 1'b1; ns_req_size = 2'b01; ns_req_addr = 9'h004; ns_req_wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    t = 1;
    while (ns_resp_valid !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
    check("t5.aligned_latency", t, 3);
    check("t5.aligned_err", {31'h0, ns_resp_err}, 32'h0);
    check("t5.aligned_strobes", ns_strobes, 1);
    @(posedge clk); #1;

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      sz  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      a   = ($urandom_range(0, 3) == 0) ? $urandom_range(504, 511) : $urandom_range(0, 511);
      lsu_op("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom, rd);
    end

    // Reset during beat 2 of a split store
    s0 = strobe_cnt;
    r0 = resp_seen;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 9'h041; req_wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (strobe_cnt < s0 + 2 && t < 40) begin @(posedge clk); #2; t++; end
    check("t6.reached_beat2", strobe_cnt - s0, 2);
    rst_n = 1'b0;
    #1;
    check("t6.enable_drop", {31'h0, mem_enable}, 32'h0);
    check("t6.resp_in_reset", {31'h0, resp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6.no_resp", resp_seen - r0, 0);
    check("t6.no_retry", strobe_cnt - s0, 2);
    check("t6.ready", {31'h0, req_ready}, 32'h1);
    check("t6.byte0", {24'h0, mem[9'h041]}, 32'hAA);
    check("t6.byte1", {24'h0, mem[9'h042]}, 32'hBB);
    check("t6.byte2", {24'h0, mem[9'h043]}, {24'h0, ref_mem[9'h043]});
    check("t6.byte3", {24'h0, mem[9'h044]}, {24'h0, ref_mem[9'h044]});
    ref_mem[9'h041] = 8'hAA;
    ref_mem[9'h042] = 8'hBB;

    diff = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diff++;
    check("mem_image", diff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
